// File: rtl/rf_pkg.sv
// rf_pkg
// Shared constants and types for the multi-port register file.
//   XLEN_DEF / NREGS_DEF : default data width and register count
//   reg_addr_t           : 5-bit register index for the default build
//   xword_t              : 32-bit register word for the default build
package rf_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  typedef logic [4:0]  reg_addr_t;
  typedef logic [31:0] xword_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
// Per-register busy tracking for the issue stage.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   wr_en        : writeback port enables (NWR)
//   wr_addr      : writeback port addresses (NWR x AW)
//   wr_clr       : writeback port busy-clear requests (NWR)
//   iss_en       : issue strobe, sets busy for iss_addr
//   iss_addr     : destination register of the issuing instruction
//   flush        : clears every busy bit
//   busy_vec     : registered busy bits (NREGS)
// Priority per register: hold < writeback clear < issue set < flush.
// Register 0 never becomes busy.
module regfile_scoreboard
  import rf_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int NWR   = 2,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NWR-1:0]         wr_en,
  input  logic [NWR-1:0][AW-1:0] wr_addr,
  input  logic [NWR-1:0]         wr_clr,
  input  logic                   iss_en,
  input  logic [AW-1:0]          iss_addr,
  input  logic                   flush,
  output logic [NREGS-1:0]       busy_vec
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  always_comb begin
    busy_d = busy_q;
    for (int r = 1; r < NREGS; r++) begin
      for (int j = 0; j < NWR; j++) begin
        if (wr_en[j] && wr_clr[j] && (wr_addr[j] == AW'(r))) begin
          busy_d[r] = 1'b0;
        end
      end
      // A new producer owns the register, so issue overrides a same-cycle clear.
      if (iss_en && (iss_addr == AW'(r))) begin
        busy_d[r] = 1'b1;
      end
      if (flush) begin
        busy_d[r] = 1'b0;
      end
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_vec = busy_q;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst_n) begin
      assert (busy_q[0] == 1'b0)
        else $error("regfile_scoreboard: busy bit 0 is set");
    end
  end
`endif

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp
// Parametrised multi-port integer register file with integrated scoreboard.
// Parameters: XLEN (data width), NREGS (power of two, >= 2), NRD read ports,
// NWR write ports (higher index wins on address collision).
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   rd_addr / rd_data   : combinational read ports (NRD)
//   rd_busy             : busy bit of each read address (NRD)
//   wr_en/addr/data/clr : writeback ports (NWR); wr_clr also clears busy
//   iss_en / iss_addr   : issue strobe, marks destination busy
//   flush               : clears all busy bits
//   busy_vec            : registered busy bits
//   x0_debug            : raw storage of register 0 (always zero)
// Build option: define REGFILE_BYPASS_EN to forward same-cycle writeback
// data (and busy clear) to the read ports.
module regfile_mp
  import rf_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = 2,
  parameter int NWR   = 2,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NRD-1:0][AW-1:0]   rd_addr,
  output logic [NRD-1:0][XLEN-1:0] rd_data,
  output logic [NRD-1:0]           rd_busy,
  input  logic [NWR-1:0]           wr_en,
  input  logic [NWR-1:0][AW-1:0]   wr_addr,
  input  logic [NWR-1:0][XLEN-1:0] wr_data,
  input  logic [NWR-1:0]           wr_clr,
  input  logic                     iss_en,
  input  logic [AW-1:0]            iss_addr,
  input  logic                     flush,
  output logic [NREGS-1:0]         busy_vec,
  output logic [XLEN-1:0]          x0_debug
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];

  regfile_scoreboard #(
    .NREGS (NREGS),
    .NWR   (NWR),
    .AW    (AW)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_clr   (wr_clr),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .flush    (flush),
    .busy_vec (busy_vec)
  );

  // Ports are applied in ascending order so the highest index wins a collision.
  always_comb begin
    regs_d = regs_q;
    for (int j = 0; j < NWR; j++) begin
      if (wr_en[j] && (wr_addr[j] != '0)) begin
        regs_d[wr_addr[j]] = wr_data[j];
      end
    end
    regs_d[0] = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NRD; i++) begin
      rd_data[i] = regs_q[rd_addr[i]];
      rd_busy[i] = busy_vec[rd_addr[i]];
`ifdef REGFILE_BYPASS_EN
      for (int j = 0; j < NWR; j++) begin
        if (wr_en[j] && (wr_addr[j] != '0) && (wr_addr[j] == rd_addr[i])) begin
          rd_data[i] = wr_data[j];
          rd_busy[i] = wr_clr[j] ? 1'b0 : busy_vec[rd_addr[i]];
        end
      end
`endif
    end
  end

  assign x0_debug = regs_q[0];

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst_n) begin
      assert (regs_q[0] == '0)
        else $error("regfile_mp: register 0 storage is non-zero");
    end
  end
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp
// Directed self-checking bench for regfile_mp: a default instance
// (32x32, 2R/2W) and a wide instance (16x64, 3R/1W).
module tb_regfile_mp;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  // Default-configuration instance
  logic [1:0][4:0]  rd_addr;
  logic [1:0][31:0] rd_data;
  logic [1:0]       rd_busy;
  logic [1:0]       wr_en;
  logic [1:0][4:0]  wr_addr;
  logic [1:0][31:0] wr_data;
  logic [1:0]       wr_clr;
  logic             iss_en;
  logic [4:0]       iss_addr;
  logic             flush;
  logic [31:0]      busy_vec;
  logic [31:0]      x0_debug;

  // Wide instance
  logic [2:0][3:0]  w_rd_addr;
  logic [2:0][63:0] w_rd_data;
  logic [2:0]       w_rd_busy;
  logic [0:0]       w_wr_en;
  logic [0:0][3:0]  w_wr_addr;
  logic [0:0][63:0] w_wr_data;
  logic [0:0]       w_wr_clr;
  logic             w_iss_en;
  logic [3:0]       w_iss_addr;
  logic             w_flush;
  logic [15:0]      w_busy_vec;
  logic [63:0]      w_x0_debug;

  int checks   = 0;
  int failures = 0;

  regfile_mp u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_clr   (wr_clr),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .flush    (flush),
    .busy_vec (busy_vec),
    .x0_debug (x0_debug)
  );

  regfile_mp #(
    .XLEN  (64),
    .NREGS (16),
    .NRD   (3),
    .NWR   (1)
  ) u_dut_wide (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_addr  (w_rd_addr),
    .rd_data  (w_rd_data),
    .rd_busy  (w_rd_busy),
    .wr_en    (w_wr_en),
    .wr_addr  (w_wr_addr),
    .wr_data  (w_wr_data),
    .wr_clr   (w_wr_clr),
    .iss_en   (w_iss_en),
    .iss_addr (w_iss_addr),
    .flush    (w_flush),
    .busy_vec (w_busy_vec),
    .x0_debug (w_x0_debug)
  );

  // Counts one comparison and reports it if the observed value differs.
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drives every strobe of the default instance for the coming edge.
  task automatic applyStimulus(
    input logic        we0, input logic [4:0] wa0, input logic [31:0] wd0, input logic c0,
    input logic        we1, input logic [4:0] wa1, input logic [31:0] wd1, input logic c1,
    input logic        iss, input logic [4:0] issa, input logic fl);
    wr_en    = {we1, we0};
    wr_addr  = {wa1, wa0};
    wr_data  = {wd1, wd0};
    wr_clr   = {c1, c0};
    iss_en   = iss;
    iss_addr = issa;
    flush    = fl;
  endtask

  task automatic applyIdle();
    applyStimulus(0, 5'd0, 32'h0, 0, 0, 5'd0, 32'h0, 0, 0, 5'd0, 0);
  endtask

  // Advances to 1 time unit past the next rising edge.
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n      = 1'b0;
    applyIdle();
    rd_addr    = '0;
    w_rd_addr  = '0;
    w_wr_en    = '0;
    w_wr_addr  = '0;
    w_wr_data  = '0;
    w_wr_clr   = '0;
    w_iss_en   = 1'b0;
    w_iss_addr = '0;
    w_flush    = 1'b0;

    #2;
    checkOutput("reset_rd0", rd_data[0], 64'h0);
    checkOutput("reset_busy_vec", busy_vec, 64'h0);
    checkOutput("reset_x0", x0_debug, 64'h0);
    #10;
    rst_n = 1'b1;
    stepCycle();

    // Plain write plus issue, then reset asserted mid-cycle with work pending
    applyStimulus(1, 5'd5, 32'hDEADBEEF, 0, 0, 5'd0, 32'h0, 0, 1, 5'd6, 0);
    stepCycle();
    applyIdle();
    rd_addr[0] = 5'd5;
    rd_addr[1] = 5'd6;
    #1;
    checkOutput("x5_write", rd_data[0], 64'hDEADBEEF);
    checkOutput("x6_issue_busy", busy_vec, 64'h40);
    checkOutput("x6_rd_busy", rd_busy[1], 64'h1);
    applyStimulus(1, 5'd5, 32'h11111111, 0, 0, 5'd0, 32'h0, 0, 1, 5'd8, 0);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_rd0", rd_data[0], 64'h0);
    checkOutput("midreset_busy_vec", busy_vec, 64'h0);
    checkOutput("midreset_x0", x0_debug, 64'h0);
    #1;
    rst_n = 1'b1;
    applyIdle();
    stepCycle();
    checkOutput("post_reset_x5", rd_data[0], 64'h0);

    // Register 0 is hardwired
    applyStimulus(1, 5'd0, 32'h12345678, 0, 1, 5'd0, 32'h12345678, 0, 1, 5'd0, 0);
    stepCycle();
    applyIdle();
    rd_addr[0] = 5'd0;
    #1;
    checkOutput("x0_read", rd_data[0], 64'h0);
    checkOutput("x0_busy_vec", busy_vec, 64'h0);
    checkOutput("x0_rd_busy", rd_busy[0], 64'h0);
    checkOutput("x0_debug", x0_debug, 64'h0);

    // Write collision: port 1 wins
    applyStimulus(1, 5'd7, 32'h11, 0, 1, 5'd7, 32'h22, 0, 0, 5'd0, 0);
    stepCycle();
    applyIdle();
    rd_addr[0] = 5'd7;
    rd_addr[1] = 5'd7;
    #1;
    checkOutput("collision_rd0", rd_data[0], 64'h22);
    checkOutput("collision_rd1", rd_data[1], 64'h22);

    // Two ports to distinct registers
    applyStimulus(1, 5'd1, 32'hA1, 0, 1, 5'd2, 32'hB2, 0, 0, 5'd0, 0);
    stepCycle();
    applyIdle();
    rd_addr[0] = 5'd1;
    rd_addr[1] = 5'd2;
    #1;
    checkOutput("dual_write_x1", rd_data[0], 64'hA1);
    checkOutput("dual_write_x2", rd_data[1], 64'hB2);

    // Issue beats same-cycle writeback clear
    applyStimulus(1, 5'd3, 32'h33, 1, 0, 5'd0, 32'h0, 0, 1, 5'd3, 0);
    stepCycle();
    applyIdle();
    rd_addr[0] = 5'd3;
    #1;
    checkOutput("set_beats_clr_vec", busy_vec, 64'h8);
    checkOutput("set_beats_clr_rd_busy", rd_busy[0], 64'h1);
    checkOutput("set_beats_clr_data", rd_data[0], 64'h33);

    // Flush beats issue; data write not blocked by flush
    applyStimulus(1, 5'd10, 32'hA5, 0, 0, 5'd0, 32'h0, 0, 1, 5'd4, 1);
    stepCycle();
    applyIdle();
    rd_addr[0] = 5'd10;
    #1;
    checkOutput("flush_busy_vec", busy_vec, 64'h0);
    checkOutput("flush_write_x10", rd_data[0], 64'hA5);

    // Writeback clear alone drops busy
    applyStimulus(0, 5'd0, 32'h0, 0, 0, 5'd0, 32'h0, 0, 1, 5'd12, 0);
    stepCycle();
    applyStimulus(1, 5'd12, 32'hC, 1, 0, 5'd0, 32'h0, 0, 0, 5'd0, 0);
    stepCycle();
    applyIdle();
    rd_addr[0] = 5'd12;
    #1;
    checkOutput("clr_busy_vec", busy_vec, 64'h0);
    checkOutput("clr_data_x12", rd_data[0], 64'hC);

    // Same-cycle writeback visibility on a busy register
    applyStimulus(0, 5'd0, 32'h0, 0, 0, 5'd0, 32'h0, 0, 1, 5'd9, 0);
    stepCycle();
    applyIdle();
    rd_addr[0] = 5'd9;
    #1;
    checkOutput("x9_busy_vec", busy_vec, 64'h200);
    applyStimulus(0, 5'd0, 32'h0, 0, 1, 5'd9, 32'hCAFE, 1, 0, 5'd0, 0);
    #1;
`ifdef REGFILE_BYPASS_EN
    checkOutput("bypass_same_data", rd_data[0], 64'hCAFE);
    checkOutput("bypass_same_busy", rd_busy[0], 64'h0);
`else
    checkOutput("bypass_same_data", rd_data[0], 64'h0);
    checkOutput("bypass_same_busy", rd_busy[0], 64'h1);
`endif
    stepCycle();
    applyIdle();
    #1;
    checkOutput("bypass_next_data", rd_data[0], 64'hCAFE);
    checkOutput("bypass_next_busy", rd_busy[0], 64'h0);
    checkOutput("bypass_next_vec", busy_vec, 64'h0);

    // Wide instance: 64-bit data on the top register, three read ports
    w_wr_en      = 1'b1;
    w_wr_addr[0] = 4'd15;
    w_wr_data[0] = 64'hFFFF_FFFF_0000_0001;
    stepCycle();
    w_wr_en   = 1'b0;
    w_rd_addr = {4'd15, 4'd15, 4'd15};
    #1;
    checkOutput("wide_rd0", w_rd_data[0], 64'hFFFF_FFFF_0000_0001);
    checkOutput("wide_rd1", w_rd_data[1], 64'hFFFF_FFFF_0000_0001);
    checkOutput("wide_rd2", w_rd_data[2], 64'hFFFF_FFFF_0000_0001);
    checkOutput("wide_x0", w_x0_debug, 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file with an integrated scoreboard. It is the next generation of the core's register file: configurable width, depth and read/write port counts, plus per-register busy tracking for the issue stage. It sits between decode/issue (reads, busy set) and writeback (writes, busy clear). With the bypass feature enabled, a same-cycle writeback is forwarded to the read ports.

## Interface
Parameters:
- `XLEN`, 32: data width of every register.
- `NREGS`, 32: register count; power of two, at least 2. Address width `AW = $clog2(NREGS)`.
- `NRD`, 2: number of read ports.
- `NWR`, 2: number of write ports. Higher index has priority.

Ports (clock and reset first):
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rd_addr`  in  NRD×AW  read addresses.
- `rd_data`  out  NRD×XLEN  read data, combinational.
- `rd_busy`  out  NRD  scoreboard bit of the addressed register, combinational.
- `wr_en`  in  NWR  write enables.
- `wr_addr`  in  NWR×AW  write addresses.
- `wr_data`  in  NWR×XLEN  write data.
- `wr_clr`  in  NWR  when set with `wr_en`, also clears the busy bit of `wr_addr`.
- `iss_en`  in  1  issue strobe: set busy for `iss_addr`.
- `iss_addr`  in  AW  destination register of the issuing instruction.
- `flush`  in  1  clear all busy bits (pipeline flush/trap).
- `busy_vec`  out  NREGS  all scoreboard bits, registered.
- `x0_debug`  out  XLEN  storage of register 0; must always read 0.

## Operation
- Register 0 is hardwired:
  - reads return 0;
  - writes are dropped;
  - `iss_en` to 0 never sets busy;
  - busy bit 0 is constant 0.
- Read: `rd_data[i] = regs[rd_addr[i]]`; `rd_busy[i] = busy[rd_addr[i]]`.
- Write: on the rising edge, each port `j` with `wr_en[j]` and `wr_addr[j] != 0` stores `wr_data[j]`.
  - If several ports target the same address, the highest `j` wins; lower ports' data is discarded.
- Scoreboard next-state, for each register `r` (evaluated in this order, last rule wins):
  1. Hold.
  2. Clear if any `wr_en[j] && wr_clr[j] && wr_addr[j]==r`.
  3. Set if `iss_en && iss_addr==r`. Set beats clear in the same cycle, because the new producer owns `r`.
  4. Clear if `flush`. Flush beats everything, including a same-cycle issue.
- Data writes are never blocked by `flush` or by busy state.
- Width rules:
  - addresses with values ≥ NREGS do not occur (power-of-two depth);
  - no truncation; `wr_data` is stored bit-exact.
- Assertions, simulation only and active while `rst_n` is high: report an error if register-0 storage or busy bit 0 is ever non-zero.

## Timing
- Reset (asynchronous assert): every register = 0, every busy bit = 0. Hence `rd_data` = 0, `rd_busy` = 0, `busy_vec` = 0, `x0_debug` = 0.
- Reset asserted mid-cycle overrides any pending write, issue or flush. The first edge after deassertion behaves normally.
- Write latency: 1 cycle. Data is visible on `rd_data` the cycle after the edge; with bypass, see Configuration.
- Busy latency:
  - a set from `iss_en` appears on `rd_busy`/`busy_vec` after the edge;
  - a clear from `wr_clr` also appears after the edge (combinational clear only with bypass).
- No handshakes; all strobes are single-cycle qualified by `clk`.

## Configuration
- `REGFILE_BYPASS_EN` defined:
  - a read whose address matches an active write port (non-zero address) returns that port's `wr_data` combinationally, highest `j` winning;
  - `rd_busy` for that address reads 0 if the matching port has `wr_clr` set, even if `iss_en` targets it the same cycle.
- Not defined: reads return stored contents only; same-cycle writes are invisible until the next cycle; `rd_busy` shows the registered bit.
- `busy_vec` is registered in both modes.

## Structure
- Package `rf_pkg`:
  - default constants `XLEN_DEF=32`, `NREGS_DEF=32`;
  - typedef `reg_addr_t` (logic [4:0]);
  - typedef `xword_t` (logic [31:0]).
- Sub-module `regfile_scoreboard` holds the busy vector, the set/clear/flush priority and the zero-register rule. The top holds storage, write arbitration and bypass muxing.

## Test plan
- Reset check: assert `rst_n`=0 mid-run after writing x5=0xDEADBEEF → all `rd_data`, `busy_vec` and `x0_debug` = 0 immediately; after release x5 reads 0.
- Register 0: write 0x12345678 to x0 from both ports, plus `iss_en` to x0 → `rd_data` for x0 = 0, `busy_vec[0]`=0, no assertion message.
- Write collision: port0 writes x7=0x11, port1 writes x7=0x22 in the same cycle → x7 reads 0x22 next cycle.
- Scoreboard priority:
  - `iss_en` x3 plus `wr_clr` x3 in the same cycle → busy[3]=1;
  - then `flush` plus `iss_en` x4 → `busy_vec`=0.
- Bypass, with `REGFILE_BYPASS_EN`: port1 writes x9=0xCAFE with `wr_clr` while x9 was busy; read x9 the same cycle → 0xCAFE, `rd_busy`=0. Without the macro → old value, `rd_busy`=1 that cycle; 0xCAFE and busy 0 the next cycle.
- Parametrised build NREGS=16, XLEN=64, NRD=3, NWR=1: write x15=0xFFFF_FFFF_0000_0001 → all three read ports return it on x15.
